// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// FSM state encoding and mode classification.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Command, serial and status bundle of the universal shift register.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
);
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] pi;
  logic [CNTW-1:0]  count;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] po;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, pi, count, sin_l, sin_r,
    input  po, sout_l, sout_r, busy, done
  );

  modport slave (
    input  start, mode, pi, count, sin_l, sin_r,
    output po, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_step.sv
// Single-step next-value unit: what po becomes after one shift/rotate.
module univ_shift_reg_step
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] po,
  input  logic [2:0]       op,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = po;
    case (op)
      MODE_SHL: nxt = {po[WIDTH-2:0], sin_r};
      MODE_SHR: nxt = {sin_l, po[WIDTH-1:1]};
      MODE_ROL: nxt = {po[WIDTH-2:0], po[WIDTH-1]};
      MODE_ROR: nxt = {po[0], po[WIDTH-1:1]};
      MODE_ASR: nxt = {po[WIDTH-1], po[WIDTH-1:1]};
      default:  nxt = po;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-position shifts and
// rotates executed one bit per cycle under an IDLE/RUN/DONE controller.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  univ_shift_reg_if.slave  bus
);

  localparam logic [CNTW-1:0] NMAX = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [2:0]       op_sel;
  logic [CNTW-1:0]  rem_q;
  logic [CNTW-1:0]  n_clamp;
  logic [WIDTH-1:0] po_q;
  logic [WIDTH-1:0] step_nxt;
  logic             accept;
  logic             shift_cmd;
  logic             load_en;
  logic             step_en;
  logic             busy;
  logic             done;

  // Counts beyond WIDTH saturate so rotates come back to the original value.
  assign n_clamp   = (bus.count > NMAX) ? NMAX : bus.count;
  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign shift_cmd = is_shift_mode(bus.mode) && (n_clamp != '0);
  // The first step happens on the accepting edge, before op_q is valid.
  assign op_sel    = (state_q == ST_RUN) ? op_q : bus.mode;

  univ_shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .po    (po_q),
    .op    (op_sel),
    .sin_l (bus.sin_l),
    .sin_r (bus.sin_r),
    .nxt   (step_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (shift_cmd && (n_clamp != ONE)) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (rem_q == ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    load_en = 1'b0;
    step_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_en = bus.start && (bus.mode == MODE_LOAD);
        step_en = bus.start && shift_cmd;
      end
      ST_RUN: begin
        busy    = 1'b1;
        step_en = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Register stage: command latch, remaining-step counter and contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= MODE_HOLD;
      rem_q <= '0;
      po_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.mode;
        rem_q <= shift_cmd ? (n_clamp - ONE) : '0;
      end else if (state_q == ST_RUN) begin
        rem_q <= rem_q - ONE;
      end
      if (load_en) begin
        po_q <= bus.pi;
      end else if (step_en) begin
        po_q <= step_nxt;
      end
    end
  end

  assign bus.po     = po_q;
  assign bus.sout_l = po_q[WIDTH-1];
  assign bus.sout_r = po_q[0];
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus randomized commands
// checked against an arithmetic reference model.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(W), .CNTW(CW)) u ();

  univ_shift_reg #(.WIDTH(W), .CNTW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] obs_po   [0:15];
  logic         obs_busy [0:15];
  logic         obs_done [0:15];
  logic         obs_sol  [0:15];
  logic         obs_sor  [0:15];
  logic         used_sl  [0:15];
  logic         used_sr  [0:15];

  // Reference: one step expressed as integer arithmetic on the value.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] v, input logic [2:0] m,
                                            input logic sl, input logic sr);
    int unsigned x;
    int unsigned full;
    int unsigned half;
    x    = v;
    full = 2 ** W;
    half = 2 ** (W - 1);
    case (m)
      MODE_SHL: x = (x * 2 + sr) % full;
      MODE_SHR: x = x / 2 + (sl ? half : 0);
      MODE_ROL: x = (x * 2) % full + x / half;
      MODE_ROR: x = x / 2 + (x % 2) * half;
      MODE_ASR: x = x / 2 + ((x >= half) ? half : 0);
      default: ;
    endcase
    return W'(x);
  endfunction

  // Issues one command and records nobs post-edge observations (no checking).
  task automatic drive_cmd(input logic [2:0] m, input int c, input logic [W-1:0] p,
                           input bit rand_fill, input logic [15:0] sl_pat,
                           input logic [15:0] sr_pat, input int nobs, input bit noise);
    @(negedge clk);
    u.start = 1'b1;
    u.mode  = m;
    u.count = CW'(c);
    u.pi    = p;
    for (int k = 0; k < nobs; k++) begin
      used_sl[k] = rand_fill ? 1'($urandom) : sl_pat[k];
      used_sr[k] = rand_fill ? 1'($urandom) : sr_pat[k];
      u.sin_l = used_sl[k];
      u.sin_r = used_sr[k];
      @(negedge clk);
      obs_po[k]   = u.po;
      obs_busy[k] = u.busy;
      obs_done[k] = u.done;
      obs_sol[k]  = u.sout_l;
      obs_sor[k]  = u.sout_r;
      if (noise && (k < nobs - 1)) begin
        u.start = 1'b1;
        u.mode  = 3'($urandom);
        u.count = CW'($urandom);
        u.pi    = W'($urandom);
      end else begin
        u.start = 1'b0;
      end
    end
    u.start = 1'b0;
  endtask

  task automatic test_reset;
    u.start = 1'b0; u.mode = MODE_HOLD; u.count = '0; u.pi = '0;
    u.sin_l = 1'b0; u.sin_r = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (u.po !== 8'h00) begin errors++; $display("FAIL reset_po: got %h expected 00", u.po); end
    checks++; if (u.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", u.busy); end
    checks++; if (u.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", u.done); end
    rst = 1'b0;
  endtask

  task automatic test_load;
    drive_cmd(MODE_LOAD, 0, 8'hA5, 1'b0, 16'h0, 16'h0, 2, 1'b0);
    checks++; if (obs_po[0] !== 8'hA5) begin errors++; $display("FAIL load_po: got %h expected a5", obs_po[0]); end
    checks++; if ({obs_busy[0], obs_done[0]} !== 2'b11) begin errors++; $display("FAIL load_done: busy/done %b%b expected 11", obs_busy[0], obs_done[0]); end
    checks++; if ({obs_busy[1], obs_done[1]} !== 2'b00) begin errors++; $display("FAIL load_idle: busy/done %b%b expected 00", obs_busy[1], obs_done[1]); end
    checks++; if ({obs_sol[0], obs_sor[0]} !== 2'b11) begin errors++; $display("FAIL load_sout: got %b%b expected 11", obs_sol[0], obs_sor[0]); end
  endtask

  task automatic test_shl_ignore_start;
    logic [W-1:0] exp_po [0:3];
    logic         exp_bs [0:3];
    logic         exp_dn [0:3];
    exp_po[0] = 8'h03; exp_po[1] = 8'h07; exp_po[2] = 8'h0F; exp_po[3] = 8'h0F;
    exp_bs[0] = 1'b1;  exp_bs[1] = 1'b1;  exp_bs[2] = 1'b1;  exp_bs[3] = 1'b0;
    exp_dn[0] = 1'b0;  exp_dn[1] = 1'b0;  exp_dn[2] = 1'b1;  exp_dn[3] = 1'b0;
    drive_cmd(MODE_LOAD, 0, 8'h81, 1'b0, 16'h0, 16'h0, 2, 1'b0);
    drive_cmd(MODE_SHL, 3, 8'h55, 1'b0, 16'h0, 16'hFFFF, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (obs_po[k] !== exp_po[k]) begin errors++; $display("FAIL shl_po[%0d]: got %h expected %h", k, obs_po[k], exp_po[k]); end
      checks++; if (obs_busy[k] !== exp_bs[k]) begin errors++; $display("FAIL shl_busy[%0d]: got %b expected %b", k, obs_busy[k], exp_bs[k]); end
      checks++; if (obs_done[k] !== exp_dn[k]) begin errors++; $display("FAIL shl_done[%0d]: got %b expected %b", k, obs_done[k], exp_dn[k]); end
    end
  endtask

  task automatic test_rotate_full;
    drive_cmd(MODE_LOAD, 0, 8'h96, 1'b0, 16'h0, 16'h0, 2, 1'b0);
    drive_cmd(MODE_ROR, 8, 8'h00, 1'b1, 16'h0, 16'h0, 9, 1'b1);
    checks++; if (obs_po[0] !== 8'h4B) begin errors++; $display("FAIL ror_first: got %h expected 4b", obs_po[0]); end
    checks++; if (obs_po[7] !== 8'h96) begin errors++; $display("FAIL ror_final: got %h expected 96", obs_po[7]); end
    checks++; if ({obs_done[6], obs_done[7]} !== 2'b01) begin errors++; $display("FAIL ror_done: got %b%b expected 01", obs_done[6], obs_done[7]); end
    checks++; if (obs_busy[8] !== 1'b0) begin errors++; $display("FAIL ror_idle: got %b expected 0", obs_busy[8]); end
    drive_cmd(MODE_ROL, 12, 8'h00, 1'b1, 16'h0, 16'h0, 10, 1'b1);
    checks++; if (obs_po[0] !== 8'h2D) begin errors++; $display("FAIL rol_first: got %h expected 2d", obs_po[0]); end
    checks++; if (obs_po[7] !== 8'h96) begin errors++; $display("FAIL rol_clamp_final: got %h expected 96", obs_po[7]); end
    checks++; if ({obs_done[7], obs_busy[8], obs_po[8]} !== {2'b10, 8'h96}) begin errors++; $display("FAIL rol_clamp_end: done/busy/po %b %b %h expected 1 0 96", obs_done[7], obs_busy[8], obs_po[8]); end
  endtask

  task automatic test_asr_shr;
    logic [W-1:0] exp_po [0:3];
    exp_po[0] = 8'hC0; exp_po[1] = 8'hE0; exp_po[2] = 8'hF0; exp_po[3] = 8'hF8;
    drive_cmd(MODE_LOAD, 0, 8'h80, 1'b0, 16'h0, 16'h0, 2, 1'b0);
    drive_cmd(MODE_ASR, 4, 8'h00, 1'b1, 16'h0, 16'h0, 5, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (obs_po[k] !== exp_po[k]) begin errors++; $display("FAIL asr_po[%0d]: got %h expected %h", k, obs_po[k], exp_po[k]); end
    end
    checks++; if (obs_done[3] !== 1'b1) begin errors++; $display("FAIL asr_done: got %b expected 1", obs_done[3]); end
    drive_cmd(MODE_SHR, 2, 8'h00, 1'b0, 16'h0001, 16'hFFFF, 3, 1'b0);
    checks++; if (obs_po[0] !== 8'hFC) begin errors++; $display("FAIL shr_po0: got %h expected fc", obs_po[0]); end
    checks++; if (obs_po[1] !== 8'h7E) begin errors++; $display("FAIL shr_po1: got %h expected 7e", obs_po[1]); end
    checks++; if ({obs_done[1], obs_busy[2]} !== 2'b10) begin errors++; $display("FAIL shr_done: got %b%b expected 10", obs_done[1], obs_busy[2]); end
  endtask

  task automatic test_noop;
    logic [2:0] modes [0:2];
    int         cnts  [0:2];
    modes[0] = MODE_SHL; cnts[0] = 0;
    modes[1] = MODE_RSVD; cnts[1] = 5;
    modes[2] = MODE_HOLD; cnts[2] = 3;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(modes[i], cnts[i], 8'hFF, 1'b0, 16'hFFFF, 16'hFFFF, 2, 1'b0);
      checks++; if (obs_po[0] !== 8'h7E) begin errors++; $display("FAIL noop_po[%0d]: got %h expected 7e", i, obs_po[0]); end
      checks++; if ({obs_busy[0], obs_done[0]} !== 2'b11) begin errors++; $display("FAIL noop_done[%0d]: got %b%b expected 11", i, obs_busy[0], obs_done[0]); end
      checks++; if ({obs_busy[1], obs_done[1], obs_po[1]} !== {2'b00, 8'h7E}) begin errors++; $display("FAIL noop_after[%0d]: got %b%b %h expected 00 7e", i, obs_busy[1], obs_done[1], obs_po[1]); end
    end
  endtask

  task automatic test_reset_mid_run;
    drive_cmd(MODE_LOAD, 0, 8'hFF, 1'b0, 16'h0, 16'h0, 2, 1'b0);
    @(negedge clk);
    u.start = 1'b1; u.mode = MODE_SHL; u.count = CW'(6); u.sin_r = 1'b0;
    @(negedge clk);
    u.start = 1'b0;
    @(negedge clk);
    checks++; if ({u.po, u.busy} !== {8'hFC, 1'b1}) begin errors++; $display("FAIL midrun_pre: got %h %b expected fc 1", u.po, u.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({u.po, u.busy, u.done} !== {8'h00, 2'b00}) begin errors++; $display("FAIL midrun_async: got %h %b%b expected 00 00", u.po, u.busy, u.done); end
    @(negedge clk);
    checks++; if ({u.po, u.busy, u.done} !== {8'h00, 2'b00}) begin errors++; $display("FAIL midrun_held: got %h %b%b expected 00 00", u.po, u.busy, u.done); end
    rst = 1'b0;
    drive_cmd(MODE_LOAD, 0, 8'h3C, 1'b0, 16'h0, 16'h0, 2, 1'b0);
    checks++; if ({obs_po[0], obs_done[0]} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL midrun_reload: got %h %b expected 3c 1", obs_po[0], obs_done[0]); end
    checks++; if (obs_busy[1] !== 1'b0) begin errors++; $display("FAIL midrun_reload_idle: got %b expected 0", obs_busy[1]); end
  endtask

  task automatic test_random;
    logic [W-1:0] expv;
    logic [W-1:0] p;
    logic [2:0]   m;
    int           c, n, nst;
    bit           shifty;
    expv = '0;
    for (int t = 0; t < 40; t++) begin
      m = (t == 0) ? MODE_LOAD : 3'($urandom);
      c = $urandom_range(0, 12);
      p = W'($urandom);
      n = (c > W) ? W : c;
      shifty = (m >= MODE_SHL) && (m <= MODE_ASR) && (n > 0);
      nst = shifty ? n : 1;
      drive_cmd(m, c, p, 1'b1, 16'h0, 16'h0, nst + 1, 1'b1);
      for (int k = 0; k <= nst; k++) begin
        if (k < nst) begin
          if (m == MODE_LOAD) expv = p;
          else if (shifty) expv = ref_step(expv, m, used_sl[k], used_sr[k]);
        end
        checks++; if (obs_po[k] !== expv) begin errors++; $display("FAIL rand_po t=%0d k=%0d mode=%0d cnt=%0d: got %h expected %h", t, k, m, c, obs_po[k], expv); end
        checks++; if (obs_busy[k] !== 1'(k < nst)) begin errors++; $display("FAIL rand_busy t=%0d k=%0d: got %b expected %b", t, k, obs_busy[k], (k < nst)); end
        checks++; if (obs_done[k] !== 1'(k == nst - 1)) begin errors++; $display("FAIL rand_done t=%0d k=%0d: got %b expected %b", t, k, obs_done[k], (k == nst - 1)); end
        checks++; if ({obs_sol[k], obs_sor[k]} !== {expv[W-1], expv[0]}) begin errors++; $display("FAIL rand_sout t=%0d k=%0d: got %b%b expected %b%b", t, k, obs_sol[k], obs_sor[k], expv[W-1], expv[0]); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_shl_ignore_start();
    test_rotate_full();
    test_asr_shr();
    test_noop();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
